// File: rtl/regbus_pkg.sv
// Shared types and default widths for the register-bus sequencer.
package regbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int unsigned BE_W       = 4;
  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first active request strictly after ptr, wrapping; purely combinational.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_c[cand]  = 1'b1;
        idx_c          = cand;
      end
    end
  end

endmodule

// File: rtl/regbus_sequencer.sv
// Arbitrates requesters onto the shared register-file bus, sequencing select/strobe
// windows with a recovery gap and returning a one-cycle done pulse per access.
module regbus_sequencer
  import regbus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned STB_CYC = 2,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ*BE_W-1:0]   be,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic [BE_W-1:0]           bus_be,
  output logic                      bus_as,
  output logic                      bus_rs_n,
  output logic                      bus_ws_n,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (STB_CYC > GAP_CYC) ? STB_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   cur_grant;
  logic                 cur_we;

  logic [NUM_REQ-1:0]   grant_c;
  logic [IDX_W-1:0]     idx_c;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [BE_W-1:0]      sel_be;

  logic                 grant_en, capture;
  logic                 as_d, rs_n_d, ws_n_d, busy_d;
  logic [NUM_REQ-1:0]   done_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (idx_c)
  );

  assign sel_we    = we[idx_c];
  assign sel_addr  = addr[32'(idx_c) * ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[32'(idx_c) * DATA_W +: DATA_W];
  assign sel_be    = be[32'(idx_c) * BE_W +: BE_W];

  // One counter times both the strobe window and the recovery gap.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    grant_en = 1'b0;
    capture  = 1'b0;
    as_d     = bus_as;
    rs_n_d   = bus_rs_n;
    ws_n_d   = bus_ws_n;
    busy_d   = busy;
    done_d   = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_d  = ACCESS;
          cnt_d    = '0;
          grant_en = 1'b1;
          as_d     = 1'b1;
          rs_n_d   = sel_we;
          ws_n_d   = !sel_we;
          busy_d   = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == CNT_W'(STB_CYC - 1)) begin
          state_d = RECOVER;
          cnt_d   = '0;
          capture = !cur_we;
          as_d    = 1'b0;
          rs_n_d  = 1'b1;
          ws_n_d  = 1'b1;
          done_d  = cur_grant;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Payload latched only at grant so requester changes mid-access are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IDX_W'(NUM_REQ - 1);
      cur_grant <= '0;
      cur_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      bus_as    <= 1'b0;
      bus_rs_n  <= 1'b1;
      bus_ws_n  <= 1'b1;
      busy      <= 1'b0;
      done      <= '0;
      rdata     <= '0;
    end else begin
      bus_as   <= as_d;
      bus_rs_n <= rs_n_d;
      bus_ws_n <= ws_n_d;
      busy     <= busy_d;
      done     <= done_d;
      if (grant_en) begin
        ptr       <= idx_c;
        cur_grant <= grant_c;
        cur_we    <= sel_we;
        bus_addr  <= sel_addr;
        bus_wdata <= sel_wdata;
        bus_be    <= sel_be;
      end
      if (capture) rdata <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_regbus_sequencer.sv
// Scoreboard bench for regbus_sequencer: stimulus queues expected completions,
// a negedge monitor checks each done pulse against the queue.
module tb_regbus_sequencer;

  localparam int NR = 2;
  localparam int AW = 24;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, we, done;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [NR*4-1:0]   be;
  logic [DW-1:0]     rdata, bus_wdata, bus_rdata;
  logic              busy, bus_as, bus_rs_n, bus_ws_n;
  logic [AW-1:0]     bus_addr;
  logic [3:0]        bus_be;

  regbus_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_as    (bus_as),
    .bus_rs_n  (bus_rs_n),
    .bus_ws_n  (bus_ws_n),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  // Register-file stand-in: address 0 reads DEADBEEF, others read A5 & address.
  assign bus_rdata = (bus_addr == '0) ? 32'hDEADBEEF : {8'hA5, bus_addr};

  typedef struct {
    int          idx;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rd;
  int          rs_cnt = 0, ws_cnt = 0, gap_cnt = 0;
  logic        seen_as = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic w, input logic [23:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] rd, input int c);
    exp_t e;
    if (!w) exp_rd = rd;
    e.idx = i; e.we = w; e.addr = a; e.wdata = d; e.be = b; e.rdata = exp_rd; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic w, input logic [23:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    be[i*4 +: 4] = b;
    req[i] = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", 64'(1), 64'(0));
    @(negedge clk);
  endtask

  task automatic single(input int i, input logic w, input logic [23:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] rd);
    int c;
    @(negedge clk);
    c = cyc;
    set_req(i, w, a, d, b);
    push(i, w, a, d, b, rd, c + 3);
    wait_until(c + 3);
    req[i] = 1'b0;
    wait_idle();
  endtask

  // Monitor: strobe/gap accounting every cycle, full compare on each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      rs_cnt = 0; ws_cnt = 0; gap_cnt = 0; seen_as = 1'b0;
    end else begin
      if (bus_as) begin
        if (!bus_rs_n) rs_cnt++;
        if (!bus_ws_n) ws_cnt++;
        if (seen_as && gap_cnt > 0) chk("as_gap_ge2", 64'(gap_cnt >= 2), 64'(1));
        seen_as = 1'b1;
        gap_cnt = 0;
      end else begin
        gap_cnt++;
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("done_onehot", 64'(done), 64'(NR'(1) << mon_e.idx));
          chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("rdata", 64'(rdata), 64'(mon_e.rdata));
          chk("bus_addr", 64'(bus_addr), 64'(mon_e.addr));
          chk("bus_wdata", 64'(bus_wdata), 64'(mon_e.we ? mon_e.wdata : bus_wdata));
          chk("bus_be", 64'(bus_be), 64'(mon_e.be));
          chk("rs_cycles", 64'(rs_cnt), 64'(mon_e.we ? 0 : 2));
          chk("ws_cycles", 64'(ws_cnt), 64'(mon_e.we ? 2 : 0));
          chk("busy_at_done", 64'(busy), 64'(1));
        end
        rs_cnt = 0;
        ws_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0; exp_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_as", 64'(bus_as), 64'(0));
    chk("rst_rs_n", 64'(bus_rs_n), 64'(1));
    chk("rst_ws_n", 64'(bus_ws_n), 64'(1));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(bus_addr), 64'(0));
    rst = 1'b0;

    // Single read, then single write (rdata must hold DEADBEEF).
    single(0, 1'b0, 24'h000000, 32'h0, 4'hF, 32'hDEADBEEF);
    single(1, 1'b1, 24'h000100, 32'h12345678, 4'hF, 32'h0);

    // Contention: both held, grants 0,1,0,1 every 4 cycles.
    @(negedge clk);
    c = cyc;
    set_req(0, 1'b0, 24'h000010, 32'h0, 4'h1);
    set_req(1, 1'b1, 24'h000020, 32'hCAFE0001, 4'h3);
    push(0, 1'b0, 24'h000010, 32'h0, 4'h1, 32'hA5000010, c + 3);
    push(1, 1'b1, 24'h000020, 32'hCAFE0001, 4'h3, 32'h0, c + 7);
    push(0, 1'b0, 24'h000010, 32'h0, 4'h1, 32'hA5000010, c + 11);
    push(1, 1'b1, 24'h000020, 32'hCAFE0001, 4'h3, 32'h0, c + 15);
    wait_until(c + 14);
    req = '0;
    wait_idle();

    // Payload change and req drop right after grant.
    @(negedge clk);
    c = cyc;
    set_req(0, 1'b0, 24'h000040, 32'h0, 4'hF);
    push(0, 1'b0, 24'h000040, 32'h0, 4'hF, 32'hA5000040, c + 3);
    wait_until(c + 1);
    req[0] = 1'b0;
    addr[0 +: AW] = 24'h0000FF;
    wait_idle();

    // Reset during the second ACCESS cycle; no done for that access.
    @(negedge clk);
    c = cyc;
    set_req(0, 1'b0, 24'h000050, 32'h0, 4'hF);
    wait_until(c + 2);
    chk("mid_access_as", 64'(bus_as), 64'(1));
    chk("mid_access_rs_n", 64'(bus_rs_n), 64'(0));
    req = '0;
    rst = 1'b1;
    #1;
    chk("rstmid_as", 64'(bus_as), 64'(0));
    chk("rstmid_rs_n", 64'(bus_rs_n), 64'(1));
    chk("rstmid_ws_n", 64'(bus_ws_n), 64'(1));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_rdata", 64'(rdata), 64'(0));
    exp_rd = '0;
    @(negedge clk);
    set_req(0, 1'b0, 24'h000010, 32'h0, 4'hF);
    set_req(1, 1'b1, 24'h000030, 32'h0BADF00D, 4'hC);
    @(negedge clk);
    chk("rsthold_done", 64'(done), 64'(0));
    c = cyc;
    rst = 1'b0;
    push(0, 1'b0, 24'h000010, 32'h0, 4'hF, 32'hA5000010, c + 3);
    push(1, 1'b1, 24'h000030, 32'h0BADF00D, 4'hC, 32'h0, c + 7);
    wait_until(c + 6);
    req = '0;
    wait_idle();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regbus_sequencer.md
# regbus_sequencer

Round-robin arbiter and strobe sequencer that shares the single ARM-style register-file bus (address / data / be / as / rs_n / ws_n) between several internal requesters. It grants one requester at a time and drives chip select and read/write strobes for a fixed access window. It captures read data and returns a one-cycle completion pulse. After each access it deasserts chip select for a recovery gap so the register file's one-access-per-select latch re-arms.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 24: bus address width.
- DATA_W, 32: bus data width.
- STB_CYC, 2: cycles chip select and strobe are held per access (>=2).
- GAP_CYC, 1: cycles chip select is held low after each access (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  access request per requester; level, held until done.
- we  in  NUM_REQ  1 = write, 0 = read; per requester.
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data.
- be  in  NUM_REQ*4  packed byte enables.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_W  read data; valid when done pulses for a read.
- busy  out  1  high from grant through the end of recovery.
- bus_addr  out  ADDR_W  to register file address.
- bus_wdata  out  DATA_W  to register file data_in.
- bus_be  out  4  to register file be.
- bus_as  out  1  chip select, active high.
- bus_rs_n  out  1  read strobe, active low.
- bus_ws_n  out  1  write strobe, active low.
- bus_rdata  in  DATA_W  from register file data_out.

## Operation
- FSM states: IDLE, ACCESS, RECOVER.
- **IDLE**
  - If any req is high, the arbiter picks the winner: first requester at or after ptr+1, wrapping modulo NUM_REQ.
  - Latch the winner's we/addr/wdata/be and its index into bus registers.
  - Go to ACCESS.
  - Set ptr to the winner only at grant.
- **ACCESS**
  - bus_as=1.
  - For a read, bus_rs_n=0; for a write, bus_ws_n=0. The other strobe stays 1.
  - Stay STB_CYC cycles, then go to RECOVER.
- **RECOVER**
  - bus_as=0, both strobes 1; bus_addr/wdata/be hold their values.
  - Stay GAP_CYC cycles, then go to IDLE.
- Read capture: at the last ACCESS edge, rdata is loaded from bus_rdata.
- done[idx] pulses for exactly the first RECOVER cycle, for both reads and writes.
- A write leaves rdata unchanged.
- Payload is sampled only at grant. Changing addr/wdata or dropping req after grant does not abort or alter the access, and done still pulses.
- After done, the requester must drop req or present a new access. A still-high req at IDLE is treated as a new request.
- Simultaneous requests are served strictly round-robin. No requester waits more than NUM_REQ-1 other accesses.
- Reset values:
  - busy=0, done=0, rdata=0.
  - bus_as=0, bus_rs_n=1, bus_ws_n=1.
  - bus_addr=0, bus_wdata=0, bus_be=0.
  - ptr=NUM_REQ-1, so requester 0 wins first.
  - State = IDLE.
- Reset asserted mid-ACCESS or mid-RECOVER forces reset values immediately (asynchronously). No done is issued for the interrupted access.

## Timing
- Edge E0: req sampled high in IDLE.
- Cycles E0+1 .. E0+STB_CYC: ACCESS, with bus outputs valid.
- Cycle E0+STB_CYC+1: done and rdata valid.
- Request-to-done latency is STB_CYC+1 cycles (3 by default).
- Minimum grant-to-grant period is 1+STB_CYC+GAP_CYC cycles (4 by default).
- bus_as is low for at least GAP_CYC cycles between accesses, plus the IDLE cycle.
- All outputs are registered; there is no combinational path from req to bus or done.
- busy is high during ACCESS and RECOVER.

## Structure
- Package regbus_pkg: state enum (IDLE, ACCESS, RECOVER), BE_W=4 constant, default ADDR_W/DATA_W.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req, ptr.
  - Outputs: one-hot grant and index, purely combinational.
  - Instantiated once.
- Cycle counter sized for max(STB_CYC, GAP_CYC), shared by ACCESS and RECOVER.

## Test plan
1. Reset: rst=1 then 0 -> bus_as=0, bus_rs_n=1, bus_ws_n=1, rdata=0, done=0, busy=0.
2. Single read: req[0]=1, we=0, addr=0, bus_rdata=32'hDEADBEEF -> bus_rs_n low for 2 cycles with bus_as=1; done[0] 3 cycles after the sampling edge; rdata=32'hDEADBEEF; bus_ws_n stays 1.
3. Single write: req[1]=1, we=1, wdata=32'h12345678, be=4'hF -> bus_ws_n low for 2 cycles; bus_wdata=32'h12345678; done[1] pulses; rdata unchanged.
4. Contention: req=2'b11 held continuously -> grants alternate 0,1,0,1; done pulses every 4 cycles; bus_as low at least 2 cycles between accesses.
5. Payload change: req[0] drops and addr changes one cycle after grant -> bus_addr keeps the original value; done[0] still pulses.
6. Reset mid-ACCESS: rst asserted in the 2nd ACCESS cycle -> bus_as=0 and strobes=1 immediately; no done; after release, requester 0 wins first.
